// File: rtl/serial_adder_top.sv
// Board-level serial adder/subtractor: a debounced push-button starts a bit-serial
// add or subtract of two switch operands, one full-adder step per clock.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);
  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (a & cin) | (b & cin);
endmodule

// Push-button conditioning: two-flop synchroniser, counter debouncer, rising-edge pulse.
module serial_adder_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic start_c
);
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            db_level;
  logic            db_level_next;
  logic            db_hist;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_level_next = db_level;
    db_cnt_next   = db_cnt;
    if (sync_q[1] != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level_next = sync_q[1];
        db_cnt_next   = '0;
      end else begin
        db_cnt_next = db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      db_hist  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      db_level <= db_level_next;
      db_cnt   <= db_cnt_next;
      db_hist  <= db_level;
    end
  end

  assign start_c = db_level & ~db_hist;
endmodule

module serial_adder_top #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BTN,
  input  logic [2*WIDTH:0]   SW,
  output logic [WIDTH+1:0]   LED
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   a_sh_next;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   b_sh_next;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   res_sh_next;
  logic               carry;
  logic               carry_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   s_next;
  logic               c_q;
  logic               c_next;
  logic               busy_q;
  logic               busy_next;

  logic               start_c;
  logic               fa_sum_c;
  logic               fa_cout_c;
  logic [WIDTH-1:0]   sw_a_c;
  logic [WIDTH-1:0]   sw_b_c;
  logic               sw_mode_c;

  assign sw_a_c    = SW[WIDTH-1:0];
  assign sw_b_c    = SW[2*WIDTH-1:WIDTH];
  assign sw_mode_c = SW[2*WIDTH];

  serial_adder_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn     (BTN),
    .start_c (start_c)
  );

  serial_adder_fa u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry),
    .sum_c  (fa_sum_c),
    .cout_c (fa_cout_c)
  );

  // Subtract is A + ~B + 1: invert B at capture and preload the carry with MODE.
  always_comb begin
    state_next   = state;
    a_sh_next    = a_sh;
    b_sh_next    = b_sh;
    res_sh_next  = res_sh;
    carry_next   = carry;
    bit_cnt_next = bit_cnt;
    s_next       = s_q;
    c_next       = c_q;
    busy_next    = busy_q;
    case (state)
      IDLE: begin
        if (start_c) begin
          a_sh_next    = sw_a_c;
          b_sh_next    = sw_mode_c ? ~sw_b_c : sw_b_c;
          carry_next   = sw_mode_c;
          bit_cnt_next = '0;
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        res_sh_next  = {fa_sum_c, res_sh[WIDTH-1:1]};
        a_sh_next    = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_next    = {1'b0, b_sh[WIDTH-1:1]};
        carry_next   = fa_cout_c;
        bit_cnt_next = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        s_next     = res_sh;
        c_next     = carry;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      a_sh    <= a_sh_next;
      b_sh    <= b_sh_next;
      res_sh  <= res_sh_next;
      carry   <= carry_next;
      bit_cnt <= bit_cnt_next;
      s_q     <= s_next;
      c_q     <= c_next;
      busy_q  <= busy_next;
    end
  end

  assign LED = {busy_q, c_q, s_q};
endmodule

// File: doc/serial_adder_top.md
# serial_adder_top

Parametrised board-level adder/subtractor: slide switches supply two WIDTH-bit operands and a mode bit, and a debounced push-button starts an operation. A single full-adder cell, reused once per clock, computes the result LSB-first over WIDTH cycles. The sum, carry and busy flag drive the LEDs. It is the sequential, N-bit, add/subtract generalisation of the switch-to-LED half-adder lab top.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the button level is accepted (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- BTN  in  1  start push-button; raw, asynchronous, may bounce
- SW  in  2*WIDTH+1  operands and mode: [WIDTH-1:0]=A, [2*WIDTH-1:WIDTH]=B, [2*WIDTH]=MODE (0 add, 1 subtract); asynchronous, quasi-static
- LED  out  WIDTH+2  [WIDTH-1:0]=S result, [WIDTH]=C carry-out, [WIDTH+1]=BUSY

## Operation
- BTN path: 2-flop synchroniser, then debouncer, then rising-edge detect.
- The edge detect produces a 1-cycle start pulse when the debounced level rises.
- Debouncer: counter increments on each edge where the synced value differs from the debounced level.
  - Any edge where they are equal clears the counter.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, the debounced level takes the synced value and the counter clears.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start pulse → capture A into the a-shift register and B into the b-shift register (B inverted when MODE=1). Carry flop ← MODE, bit counter ← 0, go to SHIFT.
  - SHIFT: each cycle, full-adder on (a_sh[0], b_sh[0], carry). The sum bit shifts into the MSB of the result shift register; a_sh and b_sh shift right; carry ← carry-out; counter increments. On the edge where counter = WIDTH-1, go to DONE.
  - DONE: S ← result register, C ← carry flop, go to IDLE.
- Arithmetic: add gives S = (A+B) mod 2^WIDTH, C = bit WIDTH of A+B. Subtract gives S = (A−B) mod 2^WIDTH, C = 1 iff A ≥ B unsigned (no borrow).
- SW is sampled only at capture. Switch changes during SHIFT/DONE do not affect the running result.
- Start pulses in SHIFT or DONE are dropped, not queued. A button held continuously produces exactly one operation.
- S and C hold their last result until the next DONE.

## Timing
- Reset (async assert): LED = all zeros, FSM = IDLE. Synchroniser flops, debounced level, edge-detect history, counters, shift registers and carry flop all clear.
- Reset released mid-operation: the block restarts in IDLE with the previous result lost (S=0, C=0).
- Clean BTN rise sampled at edge e0: synced high after e1, debounced high after e(1+DEBOUNCE_CYCLES), start pulse during the following cycle.
- Capture edge: e(2+DEBOUNCE_CYCLES). BUSY=1 from this edge.
- S, C update and BUSY=0: at edge e(3+DEBOUNCE_CYCLES+WIDTH). BUSY is high exactly WIDTH+1 cycles.
- Minimum spacing between operations is set by the debouncer: the button must be debounced low, then high again.
- Release takes the same DEBOUNCE_CYCLES, with no output effect.
- Bounce shorter than DEBOUNCE_CYCLES stable cycles never changes the debounced level.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4.

- Add: A=5, B=3, MODE=0, clean press → BUSY high 5 cycles, then S=8, C=0. Repeat with A=15, B=1 → S=0, C=1.
- Subtract: A=5, B=3, MODE=1 → S=2, C=1. Then A=3, B=5 → S=14, C=0. Then A=7, B=7 → S=0, C=1.
- Bounce: BTN toggles every 2 cycles for 12 cycles, then held high → exactly one operation; BUSY rises exactly 6 cycles after the last toggle.
- Busy lockout: second press (debounced) lands while BUSY=1; SW changed to A=1, B=1 mid-SHIFT → result reflects captured operands only; no second operation follows.
- Reset mid-SHIFT (after 2 bits, previous S=8): LED=0 immediately on assert. After release, press with A=2, B=2, MODE=0 → S=4, C=0, timing as specified.
- Exhaustive: all A, B, MODE (512 ops) → S, C match the reference arithmetic; BUSY width is always 5.
